// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The master modport is the loader's view; the slave modport is the stream source / memory side.
interface instr_loader_if #(
   parameter int A_WIDTH = 32,
   parameter int D_WIDTH = 32
);
   logic               s_valid;
   logic [7:0]         s_data;
   logic               s_ready;
   logic               mem_we;
   logic [A_WIDTH-1:0] mem_addr;
   logic [D_WIDTH-1:0] mem_wdata;

   modport master (
      input  s_valid, s_data,
      output s_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output s_valid, s_data,
      input  s_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/instr_loader.sv
// Loads a program image (count, LE payload words, XOR checksum) from a byte stream into
// instruction memory and holds the CPU in reset until a verified image is present.
module instr_loader #(
   parameter int                 A_WIDTH     = 32,
   parameter int                 D_WIDTH     = 32,
   parameter int                 DEPTH_WORDS = 256,
   parameter logic [A_WIDTH-1:0] BASE_ADDR   = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   instr_loader_if.master    bus,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_HDR0, ST_HDR1, ST_DATA, ST_WRITE, ST_CHK, ST_DONE, ST_ERROR
   } state_t;

   localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

   state_t               state_q, state_d;
   logic [15:0]          n_q, n_d;
   logic [15:0]          word_idx_q, word_idx_d;
   logic [1:0]           byte_idx_q, byte_idx_d;
   logic [7:0]           xor_q, xor_d;
   logic [D_WIDTH-1:0]   word_q, word_d;
   logic                 s_ready_q, s_ready_d;
   logic                 mem_we_q, mem_we_d;
   logic [A_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [D_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
   logic                 cpu_hold_q, cpu_hold_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 xfer;
   logic [15:0]          n_full;

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      word_idx_d  = word_idx_q;
      byte_idx_d  = byte_idx_q;
      xor_d       = xor_q;
      word_d      = word_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      xfer        = bus.s_valid && s_ready_q;
      n_full      = {bus.s_data, n_q[7:0]};

      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_HDR0;
         end
         ST_HDR0: begin
            if (xfer) begin
               n_d[7:0] = bus.s_data;
               state_d  = ST_HDR1;
            end
         end
         ST_HDR1: begin
            if (xfer) begin
               n_d = n_full;
               if (n_full == 16'd0 || {1'b0, n_full} > DEPTH_L) begin
                  state_d = ST_ERROR;
               end else begin
                  state_d    = ST_DATA;
                  word_idx_d = '0;
                  byte_idx_d = '0;
                  xor_d      = '0;
               end
            end
         end
         ST_DATA: begin
            if (xfer) begin
               word_d[{byte_idx_q, 3'b000} +: 8] = bus.s_data;
               xor_d      = xor_q ^ bus.s_data;
               byte_idx_d = byte_idx_q + 2'd1;
               // Latch the write address/data now so the strobe is registered one cycle later.
               if (byte_idx_q == 2'd3) begin
                  state_d     = ST_WRITE;
                  mem_addr_d  = BASE_ADDR + A_WIDTH'({word_idx_q, 2'b00});
                  mem_wdata_d = word_d;
               end
            end
         end
         ST_WRITE: begin
            if (word_idx_q == n_q - 16'd1) begin
               state_d = ST_CHK;
            end else begin
               word_idx_d = word_idx_q + 16'd1;
               byte_idx_d = '0;
               state_d    = ST_DATA;
            end
         end
         ST_CHK: begin
            if (xfer) state_d = (bus.s_data == xor_q) ? ST_DONE : ST_ERROR;
         end
         ST_DONE, ST_ERROR: begin
            if (start) state_d = ST_HDR0;
         end
         default: state_d = ST_IDLE;
      endcase

      // Registered outputs are a pure function of the state being entered.
      s_ready_d  = (state_d == ST_HDR0) || (state_d == ST_HDR1) ||
                   (state_d == ST_DATA) || (state_d == ST_CHK);
      mem_we_d   = (state_d == ST_WRITE);
      busy_d     = s_ready_d || (state_d == ST_WRITE);
      done_d     = (state_d == ST_DONE);
      err_d      = (state_d == ST_ERROR);
      cpu_hold_d = (state_d != ST_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         n_q         <= '0;
         word_idx_q  <= '0;
         byte_idx_q  <= '0;
         xor_q       <= '0;
         word_q      <= '0;
         s_ready_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= BASE_ADDR;
         mem_wdata_q <= '0;
         cpu_hold_q  <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         word_idx_q  <= word_idx_d;
         byte_idx_q  <= byte_idx_d;
         xor_q       <= xor_d;
         word_q      <= word_d;
         s_ready_q   <= s_ready_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_hold_q  <= cpu_hold_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign bus.s_ready   = s_ready_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign cpu_hold      = cpu_hold_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;

endmodule
